// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode-hazard definitions: register width, hazard FSM states and the
// stage-control encodings (enables, bubbles, flush) driven by the controller.
package id_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 6;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;
  } hz_ctrl_t;

  // A bubble is a NOP written into the stage register; a freeze drops its enable.
  localparam hz_ctrl_t CTRL_RESET = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam hz_ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_FRONT = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam hz_ctrl_t CTRL_MUL   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/id_hazard_ctrl_hazard_match.sv
// Compares one destination register against the ID sources; zero latency.
// r0 never matches, and only sources the ID instruction actually reads count.
module hazard_match #(
  parameter int REG_ADDR_W = 6
) (
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  output logic                  hit
);

  assign hit = (rd != '0) && ((uses_rs && (rd == rs)) || (uses_rt && (rd == rt)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode hazard controller: mul stall > load-use/branch stall > flush; controls are
// zero-latency combinational, stall counter saturates. No handshake: stalls are the backpressure.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = id_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] i_IF_ID_Rt,
  input  logic                  i_ID_uses_rs,
  input  logic                  i_ID_uses_rt,
  input  logic                  i_ID_is_branch,
  input  logic                  i_branch_taken,
  input  logic                  i_jump,
  input  logic [REG_ADDR_W-1:0] i_ID_EX_Rd,
  input  logic                  i_ID_EX_reg_write,
  input  logic                  i_ID_EX_mem_read,
  input  logic [REG_ADDR_W-1:0] i_EX_MEM_Rd,
  input  logic                  i_EX_MEM_mem_read,
  input  logic                  i_EX_mul_start,
  output logic                  o_PC_write,
  output logic                  o_IF_ID_write,
  output logic                  o_ID_EX_write,
  output logic                  o_IF_ID_flush,
  output logic                  o_ID_EX_bubble,
  output logic                  o_EX_MEM_bubble,
  output logic                  o_mul_busy,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  localparam int           CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam bit           MUL_EN   = (MUL_LAT > 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ex_hit, mem_hit;
  logic          load_use, br_hazard, front_stall, mul_stall, any_stall;
  hz_ctrl_t      ctrl;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_ex (
    .rd(i_ID_EX_Rd), .rs(i_IF_ID_Rs), .rt(i_IF_ID_Rt),
    .uses_rs(i_ID_uses_rs), .uses_rt(i_ID_uses_rt), .hit(ex_hit)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_mem (
    .rd(i_EX_MEM_Rd), .rs(i_IF_ID_Rs), .rt(i_IF_ID_Rt),
    .uses_rs(i_ID_uses_rs), .uses_rt(i_ID_uses_rt), .hit(mem_hit)
  );

  assign load_use  = i_ID_EX_mem_read && ex_hit;
  assign br_hazard = i_ID_is_branch &&
                     ((i_ID_EX_reg_write && ex_hit) || (i_EX_MEM_mem_read && mem_hit));

  // The cnt==0 MUL_BUSY cycle decodes like RUN; the start flag there is the same multiply.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (i_EX_mul_start && MUL_EN) begin
          state_d   = MUL_BUSY;
          cnt_d     = CNT_LOAD;
          mul_stall = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CW'(1);
          mul_stall = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign front_stall = !mul_stall && (load_use || br_hazard);
  assign any_stall   = mul_stall || front_stall;

  always_comb begin
    ctrl = CTRL_RUN;
    if (!i_rst_n)                         ctrl = CTRL_RESET;
    else if (mul_stall)                   ctrl = CTRL_MUL;
    else if (front_stall)                 ctrl = CTRL_FRONT;
    else if (i_branch_taken || i_jump)    ctrl = CTRL_FLUSH;
  end

  assign o_PC_write      = ctrl.pc_write;
  assign o_IF_ID_write   = ctrl.if_id_write;
  assign o_ID_EX_write   = ctrl.id_ex_write;
  assign o_IF_ID_flush   = ctrl.if_id_flush;
  assign o_ID_EX_bubble  = ctrl.id_ex_bubble;
  assign o_EX_MEM_bubble = ctrl.ex_mem_bubble;
  assign o_mul_busy      = (state_q == MUL_BUSY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      o_stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (any_stall && !(&o_stall_cycles))
        o_stall_cycles <= o_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboarded random and directed bench for id_hazard_ctrl against a
// multiply-occupancy / hazard-rule reference model.
module tb_id_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [5:0] rs, rt;
    logic       urs, urt, br, tk, jmp;
    logic [5:0] exrd;
    logic       exwr, exld;
    logic [5:0] memrd;
    logic       memld, mul;
  } stim_t;

  typedef struct {
    logic [5:0] ctrl;  // pc, if_id, id_ex, flush, id_ex_bubble, ex_mem_bubble
    logic       busy;
    int         cnt;
    int         cyc;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [5:0] rs = '0, rt = '0, exrd = '0, memrd = '0;
  logic urs = 0, urt = 0, br = 0, tk = 0, jmp = 0, exwr = 0, exld = 0, memld = 0, mul = 0;
  logic pc_w, ifid_w, idex_w, flush, idex_b, exmem_b, busy;
  logic [CNT_W-1:0] stall_cnt;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_rem = 0;   // cycles the current multiply still occupies EX, this cycle included
  int   m_cnt = 0;

  always #5 i_clk = ~i_clk;

  id_hazard_ctrl #(.REG_ADDR_W(6), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_IF_ID_Rs(rs), .i_IF_ID_Rt(rt),
    .i_ID_uses_rs(urs), .i_ID_uses_rt(urt),
    .i_ID_is_branch(br), .i_branch_taken(tk), .i_jump(jmp),
    .i_ID_EX_Rd(exrd), .i_ID_EX_reg_write(exwr), .i_ID_EX_mem_read(exld),
    .i_EX_MEM_Rd(memrd), .i_EX_MEM_mem_read(memld),
    .i_EX_mul_start(mul),
    .o_PC_write(pc_w), .o_IF_ID_write(ifid_w), .o_ID_EX_write(idex_w),
    .o_IF_ID_flush(flush), .o_ID_EX_bubble(idex_b), .o_EX_MEM_bubble(exmem_b),
    .o_mul_busy(busy), .o_stall_cycles(stall_cnt)
  );

  function automatic bit reads(input logic [5:0] rd, input stim_t s);
    return (rd != 0) && ((s.urs && rd == s.rs) || (s.urt && rd == s.rt));
  endfunction

  function automatic stim_t quiet();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    int   rem_eff;
    bit   mstall, lu, brh, front;
    @(negedge i_clk);
    i_rst_n = s.rst_n; rs = s.rs; rt = s.rt; urs = s.urs; urt = s.urt;
    br = s.br; tk = s.tk; jmp = s.jmp; exrd = s.exrd; exwr = s.exwr; exld = s.exld;
    memrd = s.memrd; memld = s.memld; mul = s.mul;
    cyc++;
    e.cyc = cyc;
    if (!s.rst_n) begin
      e.ctrl = 6'b000011; e.busy = 1'b0; e.cnt = 0;
      m_rem = 0; m_cnt = 0;
    end else begin
      rem_eff = m_rem;
      if (m_rem == 0 && s.mul && MUL_LAT > 1) rem_eff = MUL_LAT;
      e.busy = (m_rem > 0);
      mstall = (rem_eff > 1);
      lu     = s.exld && reads(s.exrd, s);
      brh    = s.br && ((s.exwr && reads(s.exrd, s)) || (s.memld && reads(s.memrd, s)));
      front  = !mstall && (lu || brh);
      if (mstall)              e.ctrl = 6'b000001;
      else if (front)          e.ctrl = 6'b001010;
      else if (s.tk || s.jmp)  e.ctrl = 6'b111100;
      else                     e.ctrl = 6'b111000;
      e.cnt = m_cnt;
      if ((mstall || front) && m_cnt < CNT_MAX) m_cnt++;
      m_rem = (rem_eff > 0) ? rem_eff - 1 : 0;
    end
    expq.push_back(e);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if ({pc_w, ifid_w, idex_w, flush, idex_b, exmem_b} !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc,
                   {pc_w, ifid_w, idex_w, flush, idex_b, exmem_b}, e.ctrl);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL mul_busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.busy);
        end
        checks++;
        if (stall_cnt !== CNT_W'(e.cnt)) begin
          errors++;
          $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.cyc, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = quiet(); s.rst_n = 1'b0;
    apply(s); apply(s);
    // load r5 in EX, ID reads r5 via Rs
    s = quiet(); s.exrd = 5; s.exwr = 1; s.exld = 1; s.rs = 5; s.urs = 1;
    apply(s); apply(quiet());
    // branch on r3 behind an ALU write, then behind a load (2 stalls, then flush)
    s = quiet(); s.br = 1; s.tk = 1; s.rs = 3; s.urs = 1; s.exrd = 3; s.exwr = 1;
    apply(s);
    s.exwr = 1; s.exld = 1; apply(s);
    s.exld = 0; s.exwr = 0; s.exrd = 0; s.memrd = 3; s.memld = 1; apply(s);
    s.memld = 0; s.memrd = 0; apply(s);
    // r0 never hazards; unused Rt never hazards
    s = quiet(); s.exrd = 0; s.exld = 1; s.exwr = 1; s.rs = 0; s.urs = 1; apply(s);
    s = quiet(); s.exrd = 7; s.exld = 1; s.exwr = 1; s.rt = 7; s.urt = 0; apply(s);
    // multiply held for MUL_LAT cycles, taken branch during the stall
    s = quiet(); s.mul = 1; s.tk = 1;
    for (int i = 0; i < MUL_LAT; i++) apply(s);
    s = quiet(); s.jmp = 1; apply(s); apply(quiet());
    // reset pulse while the multiply is busy
    s = quiet(); s.mul = 1; apply(s); apply(s);
    s.rst_n = 1'b0; apply(s);
    s = quiet(); apply(s); apply(s);
    // saturation: 20 consecutive load-use stalls
    s = quiet(); s.exrd = 9; s.exld = 1; s.rt = 9; s.urt = 1;
    for (int i = 0; i < 20; i++) apply(s);
    apply(quiet());
    // randomized traffic over a small register set to force collisions
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.rs    = 6'($urandom_range(0, 3));
      s.rt    = 6'($urandom_range(0, 3));
      s.exrd  = 6'($urandom_range(0, 3));
      s.memrd = 6'($urandom_range(0, 3));
      s.urs   = 1'($urandom_range(0, 1));
      s.urt   = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 2) == 0);
      s.tk    = s.br && ($urandom_range(0, 1) == 1);
      s.jmp   = !s.br && ($urandom_range(0, 7) == 0);
      s.exwr  = 1'($urandom_range(0, 1));
      s.exld  = s.exwr && ($urandom_range(0, 2) == 0);
      s.memld = ($urandom_range(0, 3) == 0);
      s.mul   = ($urandom_range(0, 5) == 0);
      apply(s);
    end
    @(negedge i_clk);
    #5;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
